vga_timing_gen: RTL and testbench

- Synthesizable Verilog pixel-timing generator that replaces the VHDL 640x480@60 controller.
- Sits directly upstream of the sprite/colour compositing logic in mcs_top.
- Produces registered hcount/vcount, blank, HS and VS from the 25 MHz pixel clock.
- Also produces end-of-line and end-of-frame strobes, so downstream logic can latch GPIO-driven position/colour values during vertical blanking.

---
 rtl/vga_timing_gen_if.sv | 28 ++
 rtl/vga_timing_gen.sv | 115 +++++++++++
 tb/tb_vga_timing_gen.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Timing bundle from vga_timing_gen to the compositing stages.
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        blank;
  logic        HS;
  logic        VS;
  logic        line_end;
  logic        frame_end;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  modport master (
    output hcount, vcount, blank, HS, VS, line_end, frame_end
`ifdef VGA_FRAME_CNT_EN
    , output frame_cnt
`endif
  );

  modport slave (
    input hcount, vcount, blank, HS, VS, line_end, frame_end
`ifdef VGA_FRAME_CNT_EN
    , input frame_cnt
`endif
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 pixel-timing generator: registered counts, blank, syncs and line/frame strobes.
// Optional frames-completed counter enabled by defining VGA_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0
) (
  input  logic              pixel_clk,
  input  logic              rst,
  input  logic              ce,
  vga_timing_gen_if.master  tim_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  generate
    if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_bad_geometry
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 2048");
    end
  endgenerate

  localparam logic [10:0] H_MAX    = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_MAX    = 11'(V_TOTAL - 1);
  // Thresholds are 12 bits so a region ending exactly at 2048 still compares correctly.
  localparam logic [11:0] H_VIS    = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] V_VIS    = 12'(V_ACTIVE);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        blank_q, blank_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        line_end_q, line_end_d;
  logic        frame_end_q, frame_end_d;
  logic        hWrap;
  logic [11:0] hNext;
  logic [11:0] vNext;

  // Decodes are taken from the next counts so each registered output matches its count.
  always_comb begin
    hWrap    = (hcount_q == H_MAX);
    hcount_d = hWrap ? 11'd0 : hcount_q + 11'd1;
    vcount_d = vcount_q;
    if (hWrap) begin
      vcount_d = (vcount_q == V_MAX) ? 11'd0 : vcount_q + 11'd1;
    end
    hNext       = {1'b0, hcount_d};
    vNext       = {1'b0, vcount_d};
    blank_d     = (hNext >= H_VIS) || (vNext >= V_VIS);
    hs_d        = ((hNext >= HS_START) && (hNext < HS_END)) ? HS_POL : ~HS_POL;
    vs_d        = ((vNext >= VS_START) && (vNext < VS_END)) ? VS_POL : ~VS_POL;
    line_end_d  = (hcount_d == H_MAX);
    frame_end_d = (hcount_d == H_MAX) && (vcount_d == V_MAX);
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      hcount_q    <= 11'd0;
      vcount_q    <= 11'd0;
      blank_q     <= 1'b0;
      hs_q        <= ~HS_POL;
      vs_q        <= ~VS_POL;
      line_end_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else if (ce) begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      blank_q     <= blank_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      line_end_q  <= line_end_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign tim_o.hcount    = hcount_q;
  assign tim_o.vcount    = vcount_q;
  assign tim_o.blank     = blank_q;
  assign tim_o.HS        = hs_q;
  assign tim_o.VS        = vs_q;
  assign tim_o.line_end  = line_end_q;
  assign tim_o.frame_end = frame_end_q;

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // frame_end_q marks the last pixel, so an enabled edge now wraps the frame.
  always_comb begin
    frame_cnt_d = frame_end_q ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= 16'd0;
    end else if (ce) begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign tim_o.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default geometry for line timing, a tiny
// geometry (15x10, HS active-high) so whole frames fit in a short run.
module tb_vga_timing_gen;

  logic pixelClk = 1'b0;
  logic rst;
  logic ce;
  int   checks = 0;
  int   errors = 0;

  vga_timing_gen_if bigIf ();
  vga_timing_gen_if smallIf ();

  vga_timing_gen dutBig (
    .pixel_clk (pixelClk),
    .rst       (rst),
    .ce        (ce),
    .tim_o     (bigIf)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (1),
    .HS_POL   (1'b1), .VS_POL (1'b0)
  ) dutSmall (
    .pixel_clk (pixelClk),
    .rst       (rst),
    .ce        (ce),
    .tim_o     (smallIf)
  );

  always #5 pixelClk = ~pixelClk;

  task automatic tick();
    @(posedge pixelClk);
    #1;
  endtask

  task automatic applyStimulus(input logic rstV, input logic ceV, input int cycles);
    rst = rstV;
    ce  = ceV;
    repeat (cycles) tick();
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    int leCount, leAt, blankRise, hsLow, hsFirst, hsBackAt, enabled;
    int feCount, feH, feV, vsLow, vsBad, blankCount, hsHigh, prevVs;

    rst = 1'b1;
    ce  = 1'b0;
    #2;
    tick();
    tick();
    checkOutput("rstHcount", int'(bigIf.hcount), 0);
    checkOutput("rstVcount", int'(bigIf.vcount), 0);
    checkOutput("rstBlank", int'(bigIf.blank), 0);
    checkOutput("rstHS", int'(bigIf.HS), 1);
    checkOutput("rstVS", int'(bigIf.VS), 1);
    checkOutput("rstLineEnd", int'(bigIf.line_end), 0);
    checkOutput("rstFrameEnd", int'(bigIf.frame_end), 0);
    checkOutput("rstSmallHS", int'(smallIf.HS), 0);
    checkOutput("rstSmallVS", int'(smallIf.VS), 1);

    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("firstHcount", int'(bigIf.hcount), 1);
    checkOutput("firstVcount", int'(bigIf.vcount), 0);
    checkOutput("firstBlank", int'(bigIf.blank), 0);
    checkOutput("firstHS", int'(bigIf.HS), 1);
    checkOutput("firstVS", int'(bigIf.VS), 1);
    checkOutput("firstLineEnd", int'(bigIf.line_end), 0);

    leCount = 0; leAt = -1; blankRise = -1; hsLow = 0; hsFirst = -1; hsBackAt = -1;
    for (int n = 2; n <= 799; n++) begin
      tick();
      checkOutput("lineHcount", int'(bigIf.hcount), n);
      if (bigIf.line_end) begin
        leCount++;
        leAt = int'(bigIf.hcount);
      end
      if (bigIf.blank && blankRise < 0) blankRise = int'(bigIf.hcount);
      if (!bigIf.HS) begin
        hsLow++;
        if (hsFirst < 0) hsFirst = int'(bigIf.hcount);
      end
      if (bigIf.HS && hsFirst >= 0 && hsBackAt < 0) hsBackAt = int'(bigIf.hcount);
    end
    checkOutput("lineEndCount", leCount, 1);
    checkOutput("lineEndAt", leAt, 799);
    checkOutput("blankRiseAt", blankRise, 640);
    checkOutput("hsLowCycles", hsLow, 96);
    checkOutput("hsLowFirst", hsFirst, 656);
    checkOutput("hsHighAgainAt", hsBackAt, 752);
    checkOutput("lineVcount", int'(bigIf.vcount), 0);
    checkOutput("blankAt799", int'(bigIf.blank), 1);

    tick();
    checkOutput("wrapHcount", int'(bigIf.hcount), 0);
    checkOutput("wrapVcount", int'(bigIf.vcount), 1);
    checkOutput("wrapLineEnd", int'(bigIf.line_end), 0);
    checkOutput("wrapBlank", int'(bigIf.blank), 0);

    enabled = 0;
    for (int n = 0; n < 40; n++) begin
      ce = (n % 4 == 3);
      if (ce) enabled++;
      tick();
      checkOutput("ceGateHcount", int'(bigIf.hcount), enabled);
    end
    checkOutput("ceGateVcount", int'(bigIf.vcount), 1);

    applyStimulus(1'b0, 1'b1, 290);
    checkOutput("midHcount", int'(bigIf.hcount), 300);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("asyncRstHcount", int'(bigIf.hcount), 0);
    checkOutput("asyncRstVcount", int'(bigIf.vcount), 0);
    checkOutput("asyncRstHS", int'(bigIf.HS), 1);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("resumeHcount", int'(bigIf.hcount), 1);
    checkOutput("resumeSmallHcount", int'(smallIf.hcount), 1);
`ifdef VGA_FRAME_CNT_EN
    checkOutput("frameCntStart", int'(smallIf.frame_cnt), 0);
`endif

    feCount = 0; feH = -1; feV = -1; vsLow = 0; vsBad = 0; blankCount = 0; hsHigh = 0;
    prevVs = int'(smallIf.VS);
    for (int n = 2; n <= 150; n++) begin
      tick();
      if (smallIf.frame_end) begin
        feCount++;
        feH = int'(smallIf.hcount);
        feV = int'(smallIf.vcount);
      end
      if (!smallIf.VS) vsLow++;
      if (int'(smallIf.VS) != prevVs && smallIf.hcount != 11'd0) vsBad++;
      prevVs = int'(smallIf.VS);
      if (smallIf.blank) blankCount++;
      if (smallIf.HS) hsHigh++;
    end
    checkOutput("frameEndCount", feCount, 1);
    checkOutput("frameEndH", feH, 14);
    checkOutput("frameEndV", feV, 9);
    checkOutput("vsLowCycles", vsLow, 30);
    checkOutput("vsOffWrap", vsBad, 0);
    checkOutput("blankCycles", blankCount, 102);
    checkOutput("hsHighCycles", hsHigh, 30);
    checkOutput("frameWrapH", int'(smallIf.hcount), 0);
    checkOutput("frameWrapV", int'(smallIf.vcount), 0);
`ifdef VGA_FRAME_CNT_EN
    checkOutput("frameCntOne", int'(smallIf.frame_cnt), 1);
`endif

    applyStimulus(1'b0, 1'b1, 149);
    checkOutput("frameEndAgain", int'(smallIf.frame_end), 1);
    applyStimulus(1'b0, 1'b0, 3);
    checkOutput("holdFrameEnd", int'(smallIf.frame_end), 1);
    checkOutput("holdLineEnd", int'(smallIf.line_end), 1);
    checkOutput("holdHcount", int'(smallIf.hcount), 14);
    checkOutput("holdVcount", int'(smallIf.vcount), 9);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("afterHoldH", int'(smallIf.hcount), 0);
    checkOutput("afterHoldV", int'(smallIf.vcount), 0);
    checkOutput("afterHoldFrameEnd", int'(smallIf.frame_end), 0);
`ifdef VGA_FRAME_CNT_EN
    checkOutput("frameCntTwo", int'(smallIf.frame_cnt), 2);
`endif

    applyStimulus(1'b0, 1'b1, 148);
    checkOutput("preCancelH", int'(smallIf.hcount), 13);
    checkOutput("preCancelV", int'(smallIf.vcount), 9);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("cancelRstH", int'(smallIf.hcount), 0);
    checkOutput("cancelRstV", int'(smallIf.vcount), 0);
    checkOutput("cancelRstHS", int'(smallIf.HS), 0);
    checkOutput("cancelRstVS", int'(smallIf.VS), 1);
    checkOutput("cancelRstBlank", int'(smallIf.blank), 0);
`ifdef VGA_FRAME_CNT_EN
    checkOutput("cancelRstFrameCnt", int'(smallIf.frame_cnt), 0);
`endif
    tick();
    rst = 1'b0;
    tick();
    checkOutput("cancelResumeH", int'(smallIf.hcount), 1);
    checkOutput("cancelNoFrameEnd", int'(smallIf.frame_end), 0);
    tick();
    checkOutput("cancelNoFrameEnd2", int'(smallIf.frame_end), 0);
    checkOutput("cancelLineEnd", int'(smallIf.line_end), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
